// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle arithmetic/logic, one-bit-per-cycle shifts and optional shift-add multiply.
// Define ITER_ALU_MUL_EN to build the multiplier; otherwise opcode 9 decodes as illegal.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] BussA,
    input  logic [WIDTH-1:0] BussB,
    input  logic [3:0]       ALUControl,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Output,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative,
    output logic             Illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
        OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8, OP_MUL = 4'd9
    } op_t;

    localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] work;
    logic [SHW:0]     cnt;
`ifdef ITER_ALU_MUL_EN
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
`endif

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [SHW-1:0]   amt;
    logic             is_shift;
    logic             iter_start;
    logic [WIDTH-1:0] quick_res;
    logic             quick_c;
    logic             quick_v;
    logic             quick_ill;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] exec_res;

    function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] v);
        case (op)
            OP_SLL:  return {v[WIDTH-2:0], 1'b0};
            OP_SRL:  return {1'b0, v[WIDTH-1:1]};
            default: return {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    always_comb begin
        sum     = {1'b0, BussA} + {1'b0, BussB};
        diff    = {1'b0, BussA} + {1'b0, ~BussB} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf = (BussA[WIDTH-1] == BussB[WIDTH-1]) && (sum[WIDTH-1] != BussA[WIDTH-1]);
        sub_ovf = (BussA[WIDTH-1] != BussB[WIDTH-1]) && (diff[WIDTH-1] != BussA[WIDTH-1]);
        amt     = BussB[SHW-1:0];
        is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) || (ALUControl == OP_SRA);
        // The accept edge performs the first shift, so only amounts above one need EXEC.
        iter_start = is_shift && (|amt[SHW-1:1]);
`ifdef ITER_ALU_MUL_EN
        iter_start = iter_start || (ALUControl == OP_MUL);
`endif
        quick_res = '0;
        quick_c   = 1'b0;
        quick_v   = 1'b0;
        quick_ill = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                quick_res = sum[WIDTH-1:0];
                quick_c   = sum[WIDTH];
                quick_v   = add_ovf;
            end
            OP_SUB: begin
                quick_res = diff[WIDTH-1:0];
                quick_c   = ~diff[WIDTH];
                quick_v   = sub_ovf;
            end
            OP_AND: quick_res = BussA & BussB;
            OP_OR:  quick_res = BussA | BussB;
            OP_XOR: quick_res = BussA ^ BussB;
            OP_SLT: quick_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            OP_SLL, OP_SRL, OP_SRA:
                quick_res = (amt == '0) ? BussA : shift1(ALUControl, BussA);
`ifdef ITER_ALU_MUL_EN
            OP_MUL: quick_res = '0;
`endif
            default: quick_ill = 1'b1;
        endcase
    end

    always_comb begin
        sh_next = shift1(op_q, work);
`ifdef ITER_ALU_MUL_EN
        acc_next = acc + (mplier[0] ? work : '0);
        exec_res = (op_q == OP_MUL) ? acc_next : sh_next;
`else
        exec_res = sh_next;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            InReady  <= 1'b1;
            OutValid <= 1'b0;
            Output   <= '0;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Illegal  <= 1'b0;
            op_q     <= '0;
            work     <= '0;
            cnt      <= '0;
`ifdef ITER_ALU_MUL_EN
            mplier   <= '0;
            acc      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        op_q    <= ALUControl;
                        InReady <= 1'b0;
                        if (iter_start) begin
                            state <= EXEC;
`ifdef ITER_ALU_MUL_EN
                            if (ALUControl == OP_MUL) begin
                                work   <= BussA;
                                mplier <= BussB;
                                acc    <= '0;
                                cnt    <= (SHW+1)'(WIDTH);
                            end else
`endif
                            begin
                                work <= shift1(ALUControl, BussA);
                                cnt  <= {1'b0, amt} - CNT_ONE;
                            end
                        end else begin
                            state    <= DONE;
                            OutValid <= 1'b1;
                            Output   <= quick_res;
                            CarryOut <= quick_c;
                            Overflow <= quick_v;
                            Zero     <= (quick_res == '0);
                            Negative <= quick_res[WIDTH-1];
                            Illegal  <= quick_ill;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == CNT_ONE) begin
                        state    <= DONE;
                        OutValid <= 1'b1;
                        Output   <= exec_res;
                        CarryOut <= 1'b0;
                        Overflow <= 1'b0;
                        Zero     <= (exec_res == '0);
                        Negative <= exec_res[WIDTH-1];
                        Illegal  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
`ifdef ITER_ALU_MUL_EN
                        if (op_q == OP_MUL) begin
                            work   <= {work[WIDTH-2:0], 1'b0};
                            mplier <= {1'b0, mplier[WIDTH-1:1]};
                            acc    <= acc_next;
                        end else
`endif
                        work <= sh_next;
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        state    <= IDLE;
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    OutValid <= 1'b0;
                    InReady  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (WIDTH=32): driver queues expected results, negedge monitor checks them.
module tb_iter_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [W-1:0] BussA = '0;
    logic [W-1:0] BussB = '0;
    logic [3:0]   ALUControl = '0;
    logic         OutValid;
    logic         OutReady = 1'b1;
    logic [W-1:0] Output;
    logic         CarryOut, Overflow, Zero, Negative, Illegal;

    iter_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady),
        .BussA(BussA), .BussB(BussB), .ALUControl(ALUControl),
        .OutValid(OutValid), .OutReady(OutReady), .Output(Output),
        .CarryOut(CarryOut), .Overflow(Overflow), .Zero(Zero),
        .Negative(Negative), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] out;
        logic [4:0]   fl;   // {carry, overflow, zero, negative, illegal}
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   consumed = 0;
    logic prev_v = 1'b0;
    logic post_hs = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: result checks on OutValid rise, stability at handshake, InReady the cycle after.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v  = 1'b0;
            post_hs = 1'b0;
        end else begin
            if (post_hs) begin
                chk({cur.name, "-ready-after"}, {62'd0, InReady, OutValid}, 64'b10);
                post_hs = 1'b0;
            end
            if (OutValid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected-result", 64'd1, 64'd0);
                    cur.name = "unexpected";
                    cur.out  = Output;
                end else begin
                    cur = q.pop_front();
                    chk({cur.name, "-lat"}, 64'(cyc - cur.acc + 1), 64'(cur.lat));
                    chk({cur.name, "-out"}, 64'(Output), 64'(cur.out));
                    chk({cur.name, "-flags"}, 64'({CarryOut, Overflow, Zero, Negative, Illegal}), 64'(cur.fl));
                    chk({cur.name, "-inready-low"}, 64'(InReady), 64'd0);
                end
            end
            if (OutValid && OutReady) begin
                chk({cur.name, "-stable"}, 64'(Output), 64'(cur.out));
                post_hs = 1'b1;
                consumed++;
            end
            prev_v = OutValid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eo, input logic [4:0] ef,
                         input int lat, input int hold);
        exp_t e;
        int   tgt;
        int   t;
        tgt = consumed + 1;
        step();
        t = 0;
        while (!InReady && t < 100) begin
            step();
            t++;
        end
        if (!InReady) begin
            chk({name, "-inready-timeout"}, 64'd0, 64'd1);
            return;
        end
        OutReady   = (hold == 0);
        InValid    = 1'b1;
        ALUControl = op;
        BussA      = a;
        BussB      = b;
        step();
        e.name = name;
        e.out  = eo;
        e.fl   = ef;
        e.lat  = lat;
        e.acc  = cyc;
        q.push_back(e);
        InValid    = 1'b0;
        BussA      = $urandom;
        BussB      = $urandom;
        ALUControl = 4'($urandom_range(0, 15));
        if (hold > 0) begin
            t = 0;
            while (!OutValid && t < 100) begin
                step();
                t++;
            end
            repeat (hold) begin
                step();
                InValid    = 1'b1;
                BussA      = $urandom;
                ALUControl = 4'd0;
            end
            chk({name, "-held-out"}, 64'(Output), 64'(eo));
            chk({name, "-held-valid"}, {62'd0, OutValid, InReady}, 64'b10);
            InValid  = 1'b0;
            OutReady = 1'b1;
        end
        t = 0;
        while (consumed < tgt && t < 200) begin
            step();
            t++;
        end
        if (consumed < tgt) begin
            chk({name, "-timeout"}, 64'd0, 64'd1);
            q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset-state", {30'd0, InReady, OutValid, Output},
            {30'd0, 1'b1, 1'b0, 32'h0});
        chk("reset-flags", 64'({CarryOut, Overflow, Zero, Negative, Illegal}), 64'd0);
        step();
        reset_n = 1'b1;

        issue("add-ovf",   4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010, 1, 0);
        issue("sub-borrow",4'd1, 32'd3,        32'd5,        32'hFFFFFFFE, 5'b10010, 1, 0);
        issue("slt-neg",   4'd5, 32'h80000000, 32'h00000001, 32'h00000001, 5'b00000, 1, 0);
        issue("sra-4",     4'd8, 32'h80000000, 32'd4,        32'hF8000000, 5'b00010, 4, 0);
        issue("sll-0",     4'd6, 32'h12345678, 32'h00000020, 32'h12345678, 5'b00000, 1, 0);
        issue("and",       4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b00010, 1, 0);
        issue("or",        4'd3, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 5'b00000, 1, 0);
        issue("xor-zero",  4'd4, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 5'b00100, 1, 0);
        issue("srl-1",     4'd7, 32'h80000001, 32'd1,        32'h40000000, 5'b00000, 1, 0);
        issue("sll-31",    4'd6, 32'h00000001, 32'd31,       32'h80000000, 5'b00010, 31, 0);
        issue("illegal15", 4'd15,32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b00101, 1, 0);
        issue("add-carry", 4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100, 1, 0);
        issue("sub-pos",   4'd1, 32'd5,        32'd3,        32'h00000002, 5'b00000, 1, 0);
        issue("slt-false", 4'd5, 32'h00000001, 32'h80000000, 32'h00000000, 5'b00100, 1, 0);
        issue("sub-ovf",   4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b01000, 1, 0);
        issue("sra-31",    4'd8, 32'h40000000, 32'd31,       32'h00000000, 5'b00100, 31, 0);
        issue("sra-2",     4'd8, 32'hFFFFFFF0, 32'd2,        32'hFFFFFFFC, 5'b00010, 2, 0);
`ifdef ITER_ALU_MUL_EN
        issue("mul-16x16", 4'd9, 32'h00010000, 32'h00010000, 32'h00000000, 5'b00100, 33, 0);
        issue("mul-7x6",   4'd9, 32'd7,        32'd6,        32'd42,       5'b00000, 33, 0);
`else
        issue("mul-illegal", 4'd9, 32'h00010000, 32'h00010000, 32'h00000000, 5'b00101, 1, 0);
`endif
        issue("backpress", 4'd0, 32'd1,        32'd2,        32'd3,        5'b00000, 1, 10);

        // Reset in the middle of a long operation; nothing must be reported for it.
        issue("pre-reset", 4'd3, 32'h00005500, 32'h00000055, 32'h00005555, 5'b00000, 1, 0);
        step();
        InValid    = 1'b1;
`ifdef ITER_ALU_MUL_EN
        ALUControl = 4'd9;
`else
        ALUControl = 4'd8;
`endif
        BussA = 32'h80000000;
        BussB = 32'd31;
        step();
        InValid = 1'b0;
        repeat (5) step();
        chk("mid-exec-busy", {62'd0, OutValid, InReady}, 64'b00);
        reset_n = 1'b0;
        #1;
        chk("rst-async", {30'd0, InReady, OutValid, Output}, {30'd0, 1'b1, 1'b0, 32'h0});
        chk("rst-flags", 64'({CarryOut, Overflow, Zero, Negative, Illegal}), 64'd0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (40) step();
        issue("post-reset", 4'd0, 32'd10, 32'd20, 32'd30, 5'b00000, 1, 0);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 InValid  in  1  operand/opcode present.
REQ-006 InReady  out  1  block can accept an operation.
REQ-007 BussA, BussB  in  WIDTH each  operands, captured on accept.
REQ-008 ALUControl  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA, 9 MUL, 10-15 illegal.
REQ-009 OutValid  out  1  result held and valid.
REQ-010 OutReady  in  1  consumer takes result.
REQ-011 Output  out  WIDTH  result.
REQ-012 CarryOut, Overflow, Zero, Negative  out  1 each  result flags.
REQ-013 Illegal  out  1  held opcode was 10-15.

Function
REQ-014 FSM states IDLE, EXEC, DONE; InReady SHALL be 1 only in IDLE.
REQ-015 Accept SHALL occur when InValid and InReady are both 1; operands and opcode registered, BussA/BussB/ALUControl ignored otherwise.
REQ-016 ADD/SUB/AND/OR/XOR/SLT/illegal: IDLE->DONE, OutValid high the cycle after accept (latency 1).
REQ-017 SLL/SRL/SRA: amount n = BussB[SHW-1:0]; one bit shifted per EXEC cycle; OutValid after max(1,n) cycles; n=0 returns BussA.
REQ-018 MUL: shift-add, one multiplier bit per EXEC cycle, OutValid exactly WIDTH+1 cycles after accept; Output = low WIDTH bits of unsigned product.
REQ-019 DONE: Output and flags SHALL stay stable until OutValid and OutReady both 1; then state->IDLE, InReady=1 the following cycle (no same-cycle re-accept).
REQ-020 ADD: CarryOut = carry out of MSB; Overflow = signed overflow.
REQ-021 SUB: computed as A + ~B + 1; CarryOut = 1 iff A < B unsigned (borrow); Overflow = signed overflow.
REQ-022 SLT: Output = 1 iff A < B signed, overflow-corrected; CarryOut, Overflow = 0.
REQ-023 Logic, shifts, MUL: CarryOut = Overflow = 0.
REQ-024 Zero = (Output == 0), Negative = Output[WIDTH-1], for every opcode.
REQ-025 Illegal opcode: Output = 0, Zero = 1, Illegal = 1, latency 1.
REQ-026 In IDLE/EXEC, OutValid = 0; Output and flags hold previous values.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, OutValid=0, Output=0, all flags and Illegal=0; InReady=1 while reset_n low.
REQ-028 Reset mid-EXEC or mid-DONE SHALL discard the operation; no result is ever presented for it.

Configuration
REQ-029 Macro ITER_ALU_MUL_EN: defined -> MUL per REQ-018; undefined -> opcode 9 is illegal per REQ-025 and no multiplier datapath/state is synthesised.

Verification
REQ-030 WIDTH=32, ADD 0x7FFFFFFF+1 -> 1 cycle, Output 0x80000000, Overflow 1, Negative 1, CarryOut 0.
REQ-031 SUB 3-5 -> Output 0xFFFFFFFE, CarryOut 1; SLT 0x80000000 vs 1 -> Output 1.
REQ-032 SRA 0x80000000 by 4 -> OutValid after 4 cycles, Output 0xF8000000; SLL by 0 -> latency 1, Output = A.
REQ-033 MUL 0x10000 x 0x10000 (MUL_EN) -> 33 cycles, Output 0, Zero 1; without MUL_EN -> Illegal 1, latency 1.
REQ-034 OutReady held low 10 cycles in DONE -> Output stable, InValid ignored; OutReady high -> InReady high next cycle.
REQ-035 reset_n pulsed low during MUL EXEC -> outputs zero immediately, no OutValid afterwards, next op completes normally.
